// File: rtl/uart_rx.sv
// UART receiver: 2-flop rx synchroniser, centre sampling at OVERSAMPLE ticks per bit, break lockout.
// Optional even-parity stage and parity_err port when UART_RX_PARITY_EN is defined.
`default_nettype none

module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic rx_meta_q, rx_s_q;

  state_e                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;
  logic                   lock_q, lock_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   perr_q, perr_d;
`endif

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      lock_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      lock_q    <= lock_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = ferr_q;
    // Lockout drops on the first high sample of the line.
    lock_d    = lock_q & ~rx_s_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s_q && !lock_q) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (baud_tick) begin
          if (tick_q == HALF_M1) begin
            if (!rx_s_q) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (tick_q == FULL_M1) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          if (tick_q == FULL_M1) begin
            par_bit_d = rx_s_q;
            tick_d    = '0;
            state_d   = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (baud_tick) begin
          if (tick_q == FULL_M1) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s_q;
            lock_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shift_q) ^ par_bit_q;
`endif
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx_data    = data_q;
  assign rx_done    = done_q;
  assign rx_busy    = (state_q != IDLE);
  assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; expected frames come from byte/stop/parity arithmetic.
module tb_uart_rx;

  localparam int DATA_BITS = 8;
  localparam int OS        = 16;
  localparam int TP        = 4;
  localparam int BITCLK    = OS * TP;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 baud_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_busy;
  logic                 frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  uart_rx #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Free-running baud tick: one pulse every TP clocks.
  initial begin
    baud_tick = 1'b0;
    forever begin
      for (int i = 0; i < TP; i++) begin
        @(negedge clk);
        baud_tick = (i == TP - 1);
      end
    end
  end

  // Each entry: {parity_err, frame_err, data}
  logic [DATA_BITS+1:0] act_q[$];
  logic [DATA_BITS+1:0] exp_q[$];

  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
`ifdef UART_RX_PARITY_EN
      act_q.push_back({parity_err, frame_err, rx_data});
`else
      act_q.push_back({1'b0, frame_err, rx_data});
`endif
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop, input logic par_flip);
    logic perr;
    perr = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
    perr = par_flip;
`endif
    rx = stop;
    repeat (BITCLK * 3 / 4) @(negedge clk);
    chk("busy_late_stop", rx_busy, 1'b0);
    repeat (BITCLK - BITCLK * 3 / 4) @(negedge clk);
    exp_q.push_back({perr, ~stop, d});
  endtask

  task automatic flush(input string tag);
    int n;
    chk({tag, "_count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, act_q[i], exp_q[i]);
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got %0d vectors expected completion", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_BITS-1:0] d;
    logic                 stop;
    logic                 flip;
    int                   gap;

    rx  = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, '0);
    chk("rst_done", rx_done, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
`ifdef UART_RX_PARITY_EN
    chk("rst_perr", parity_err, 1'b0);
`endif
    rst = 1'b1;
    idle(2 * BITCLK);

    send_frame(8'h55, 1'b1, 1'b0);
    idle(BITCLK);
    flush("f55");

    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(BITCLK);
    flush("b2b");

    // Start glitch shorter than half a bit.
    rx = 1'b0;
    repeat (4 * TP) @(negedge clk);
    idle(2 * BITCLK);
    chk("glitch_busy", rx_busy, 1'b0);
    chk("glitch_hold", rx_data, 8'h0F);
    flush("glitch");
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(BITCLK);
    flush("after_glitch");

    // Bad stop bit followed by a long break.
    send_frame(8'h81, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (30 * BITCLK) @(negedge clk);
    idle(2 * BITCLK);
    flush("break");
    send_frame(8'h42, 1'b1, 1'b0);
    idle(BITCLK);
    flush("after_break");

    // Reset during data bit 4 of 0xFF.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (BITCLK / 2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_data", rx_data, '0);
    chk("async_rst_busy", rx_busy, 1'b0);
    chk("async_rst_done", rx_done, 1'b0);
    chk("async_rst_ferr", frame_err, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (BITCLK / 2) @(negedge clk);
    for (int i = 5; i < DATA_BITS; i++) send_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0);
`endif
    send_bit(1'b1);
    idle(BITCLK);
    flush("aborted");
    send_frame(8'h12, 1'b1, 1'b0);
    idle(BITCLK);
    flush("after_rst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(BITCLK);
    flush("parity");
`endif

    for (int k = 0; k < 16; k++) begin
      d    = DATA_BITS'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      flip = 1'($urandom_range(0, 1));
      send_frame(d, stop, flip);
      gap = stop ? int'($urandom_range(0, 2 * BITCLK)) : BITCLK + int'($urandom_range(8, BITCLK));
      if (gap > 0) idle(gap);
      rx = 1'b1;
    end
    idle(BITCLK);
    flush("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
